// File: rtl/hsosc_pwr_ctrl_pkg.sv
// hsosc_pwr_ctrl_pkg: shared state encoding and counter sizing for the HSOSC power sequencer
package hsosc_pwr_ctrl_pkg;

    typedef enum logic [2:0] {ST_OFF, ST_PWRUP, ST_ON, ST_HOLD, ST_DRAIN} hsosc_state_t;

    function automatic int cnt_width(int pu, int idle, int off);
        int m = pu;
        int w = 1;
        m = (idle > m) ? idle : m;
        m = (off > m) ? off : m;
        while ((1 << w) < m + 1) w++;
        return w;
    endfunction

endpackage

// File: rtl/hsosc_pwr_timer.sv
// hsosc_pwr_timer: loadable down-counter that holds at zero
module hsosc_pwr_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    assign zero = (cnt == '0);

    // load has priority over decrement; decrement never wraps below zero
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && !zero) cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/hsosc_pwr_ctrl.sv
// hsosc_pwr_ctrl: request merge and power-up/enable sequencing for the iCE40UP HSOSC
// Optional power-up statistics counter enabled by defining HSOSC_PWR_CTRL_STATS_EN.
module hsosc_pwr_ctrl
    import hsosc_pwr_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int PU_CYCLES   = 1200,
    parameter int IDLE_CYCLES = 600,
    parameter int OFF_CYCLES  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               hf_ready,
    output logic               hf_pu,
    output logic               hf_en
`ifdef HSOSC_PWR_CTRL_STATS_EN
    ,
    output logic [15:0]        pu_count
`endif
);

    localparam int W = cnt_width(PU_CYCLES, IDLE_CYCLES, OFF_CYCLES);
    localparam logic [W-1:0] PU_LOAD   = W'(PU_CYCLES - 1);
    localparam logic [W-1:0] IDLE_LOAD = W'(IDLE_CYCLES - 1);
    localparam logic [W-1:0] OFF_LOAD  = W'(OFF_CYCLES - 1);

    hsosc_state_t state, nxt;
    logic         any, ld, dec, zero;
    logic [W-1:0] lv;

    assign any      = |req;
    assign hf_ready = hf_en;
    assign gnt      = req & {NUM_REQ{hf_ready}};

    hsosc_pwr_timer #(.W(W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (ld),
        .load_val (lv),
        .dec      (dec),
        .zero     (zero)
    );

    // next state and timer control; HOLD checks requests before hold-off expiry
    always_comb begin
        nxt = state;
        ld  = 1'b0;
        lv  = '0;
        dec = 1'b0;
        case (state)
            ST_OFF: if (any) begin
                nxt = ST_PWRUP;
                ld  = 1'b1;
                lv  = PU_LOAD;
            end
            ST_PWRUP: if (zero) nxt = ST_ON; else dec = 1'b1;
            ST_ON: if (!any) begin
                nxt = (IDLE_CYCLES == 0) ? ST_DRAIN : ST_HOLD;
                ld  = 1'b1;
                lv  = (IDLE_CYCLES == 0) ? OFF_LOAD : IDLE_LOAD;
            end
            ST_HOLD: if (any) nxt = ST_ON;
                else if (zero) begin
                    nxt = ST_DRAIN;
                    ld  = 1'b1;
                    lv  = OFF_LOAD;
                end else dec = 1'b1;
            ST_DRAIN: if (zero) begin
                nxt = any ? ST_PWRUP : ST_OFF;
                ld  = any;
                lv  = PU_LOAD;
            end else dec = 1'b1;
            default: nxt = ST_OFF;
        endcase
    end

    // pins follow the next state so they change on the same edge as the transition
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_OFF;
            hf_pu <= 1'b0;
            hf_en <= 1'b0;
        end else begin
            state <= nxt;
            hf_pu <= (nxt != ST_OFF);
            hf_en <= (nxt == ST_ON) || (nxt == ST_HOLD);
        end
    end

`ifdef HSOSC_PWR_CTRL_STATS_EN
    // count every entry into PWRUP, saturating
    always_ff @(posedge clk) begin
        if (reset) pu_count <= '0;
        else if (nxt == ST_PWRUP && state != ST_PWRUP && pu_count != 16'hFFFF) pu_count <= pu_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_hsosc_pwr_ctrl.sv
// tb_hsosc_pwr_ctrl: directed self-checking bench for hsosc_pwr_ctrl (PU=4, IDLE=3, OFF=2, NUM_REQ=2)
module tb_hsosc_pwr_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] gnt;
    logic       hf_ready, hf_pu, hf_en;
`ifdef HSOSC_PWR_CTRL_STATS_EN
    logic [15:0] pu_count;
`endif
    int checks = 0;
    int passed = 0;

    hsosc_pwr_ctrl #(.NUM_REQ(2), .PU_CYCLES(4), .IDLE_CYCLES(3), .OFF_CYCLES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .gnt      (gnt),
        .hf_ready (hf_ready),
        .hf_pu    (hf_pu),
        .hf_en    (hf_en)
`ifdef HSOSC_PWR_CTRL_STATS_EN
        ,
        .pu_count (pu_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 2'b00;
        tick();
        tick();
        checks++; if (hf_pu !== 1'b0) $display("FAIL reset_pu got %b exp 0", hf_pu); else passed++;
        checks++; if (hf_en !== 1'b0) $display("FAIL reset_en got %b exp 0", hf_en); else passed++;
        checks++; if (hf_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", hf_ready); else passed++;
        checks++; if (gnt !== 2'b00) $display("FAIL reset_gnt got %b exp 00", gnt); else passed++;
`ifdef HSOSC_PWR_CTRL_STATS_EN
        checks++; if (pu_count !== 16'd0) $display("FAIL reset_pucnt got %0d exp 0", pu_count); else passed++;
`endif
        reset = 1'b0;
    endtask

    task automatic test_powerup();
        req = 2'b01;
        tick();
        checks++; if (hf_pu !== 1'b1) $display("FAIL pwrup_pu_e0 got %b exp 1", hf_pu); else passed++;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (hf_en !== 1'b0) $display("FAIL pwrup_en_e%0d got %b exp 0", i, hf_en); else passed++;
        end
        tick();
        checks++; if (hf_en !== 1'b1) $display("FAIL pwrup_en_e4 got %b exp 1", hf_en); else passed++;
        checks++; if (hf_ready !== 1'b1) $display("FAIL pwrup_ready_e4 got %b exp 1", hf_ready); else passed++;
        checks++; if (gnt !== 2'b01) $display("FAIL pwrup_gnt got %b exp 01", gnt); else passed++;
        req = 2'b11;
        #1;
        checks++; if (gnt !== 2'b11) $display("FAIL pwrup_gnt_both got %b exp 11", gnt); else passed++;
        req = 2'b01;
    endtask

    task automatic test_idle_off();
        logic [5:0] exp_en = 6'b000111;
        logic [5:0] exp_pu = 6'b011111;
        req = 2'b00;
        for (int i = 0; i <= 5; i++) begin
            tick();
            checks++; if (hf_en !== exp_en[i]) $display("FAIL idle_en_m%0d got %b exp %b", i, hf_en, exp_en[i]); else passed++;
            checks++; if (hf_pu !== exp_pu[i]) $display("FAIL idle_pu_m%0d got %b exp %b", i, hf_pu, exp_pu[i]); else passed++;
        end
    endtask

    task automatic test_hold_resume();
        req = 2'b01;
        repeat (5) tick();
        checks++; if (hf_en !== 1'b1) $display("FAIL hold_setup_en got %b exp 1", hf_en); else passed++;
        req = 2'b00;
        tick();
        tick();
        req = 2'b10;
        #1;
        checks++; if (gnt !== 2'b10) $display("FAIL hold_gnt_now got %b exp 10", gnt); else passed++;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (hf_en !== 1'b1) $display("FAIL hold_en_c%0d got %b exp 1", i, hf_en); else passed++;
        end
    endtask

    task automatic test_drain_req();
        req = 2'b00;
        repeat (4) tick();
        checks++; if (hf_en !== 1'b0) $display("FAIL drain_entry_en got %b exp 0", hf_en); else passed++;
        req = 2'b01;
        for (int i = 4; i <= 9; i++) begin
            tick();
            checks++; if (hf_pu !== 1'b1) $display("FAIL drain_pu_e%0d got %b exp 1", i, hf_pu); else passed++;
            checks++; if (hf_en !== (i == 9)) $display("FAIL drain_en_e%0d got %b exp %b", i, hf_en, (i == 9)); else passed++;
        end
        req = 2'b00;
        repeat (6) tick();
        checks++; if (hf_pu !== 1'b0) $display("FAIL drain_off_pu got %b exp 0", hf_pu); else passed++;
    endtask

    task automatic test_pulse();
        logic [10:0] exp_en = 11'b00011110000;
        logic [10:0] exp_pu = 11'b01111111111;
        req = 2'b01;
        for (int i = 0; i <= 10; i++) begin
            tick();
            req = 2'b00;
            checks++; if (hf_en !== exp_en[i]) $display("FAIL pulse_en_e%0d got %b exp %b", i, hf_en, exp_en[i]); else passed++;
            checks++; if (hf_pu !== exp_pu[i]) $display("FAIL pulse_pu_e%0d got %b exp %b", i, hf_pu, exp_pu[i]); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        req = 2'b01;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++; if ({hf_pu, hf_en, hf_ready} !== 3'b000) $display("FAIL rst_pwrup got %b exp 000", {hf_pu, hf_en, hf_ready}); else passed++;
        reset = 1'b0;
        repeat (5) tick();
        checks++; if (hf_en !== 1'b1) $display("FAIL rst_on_setup got %b exp 1", hf_en); else passed++;
        reset = 1'b1;
        tick();
        checks++; if ({hf_pu, hf_en, hf_ready, gnt} !== 5'b0) $display("FAIL rst_on got %b exp 00000", {hf_pu, hf_en, hf_ready, gnt}); else passed++;
`ifdef HSOSC_PWR_CTRL_STATS_EN
        checks++; if (pu_count !== 16'd0) $display("FAIL rst_on_pucnt got %0d exp 0", pu_count); else passed++;
`endif
        req = 2'b00;
        tick();
        reset = 1'b0;
    endtask

`ifdef HSOSC_PWR_CTRL_STATS_EN
    task automatic test_stats();
        for (int k = 0; k < 3; k++) begin
            req = 2'b01;
            tick();
            req = 2'b00;
            repeat (12) tick();
        end
        checks++; if (pu_count !== 16'd3) $display("FAIL stats_pucnt got %0d exp 3", pu_count); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_powerup();
        test_idle_off();
        test_hold_resume();
        test_drain_req();
        test_pulse();
        test_reset_mid();
`ifdef HSOSC_PWR_CTRL_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
